// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART TX arbiter: FSM state encoding and counter width.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int CNT_W      = 8;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle; master is the arbiter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic                      tx_done;
  logic [IDX_W-1:0]          active_id;
  logic                      idle;
  logic                      timeout;

  modport master (
    input  req, req_data, tx_busy, tx_done,
    output grant, tx_start, tx_data, active_id, idle, timeout
  );

  modport slave (
    output req, req_data, tx_busy, tx_done,
    input  grant, tx_start, tx_data, active_id, idle, timeout
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin select: first set req bit at or above ptr, wrapping to 0.
module uart_tx_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int k;

  // Scan from farthest to nearest so the candidate closest to ptr wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = |req;
    k      = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (req[k]) begin
        idx    = IDX_W'(k);
        onehot = NUM_REQ'(1) << k;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int BUSY_TIMEOUT = 15,
  parameter int GAP_CYCLES   = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  uart_tx_arbiter_if.master  bus
);

  // state      | meaning
  // IDLE       | sampling req, grant issued on the edge a req is seen
  // WAIT_BUSY  | byte handed over, waiting for tx_busy (bounded by BUSY_TIMEOUT)
  // WAIT_DONE  | frame on the line, waiting for tx_done
  // GAP        | forced idle time before the next arbitration

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  pick_data;
  logic [IDX_W-1:0]   next_ptr;
  state_t             after_done;

  uart_tx_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign pick_data  = bus.req_data[int'(pick_idx)*DATA_W +: DATA_W];
  assign next_ptr   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
  assign after_done = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
  assign bus.idle   = (state == ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      cnt           <= '0;
      bus.grant     <= '0;
      bus.tx_start  <= 1'b0;
      bus.tx_data   <= '0;
      bus.active_id <= '0;
      bus.timeout   <= 1'b0;
    end else begin
      bus.grant    <= '0;
      bus.tx_start <= 1'b0;
      bus.timeout  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            bus.grant     <= pick_onehot;
            bus.tx_start  <= 1'b1;
            bus.tx_data   <= pick_data;
            bus.active_id <= pick_idx;
            ptr           <= next_ptr;
            cnt           <= '0;
            state         <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          // A done without a visible busy still counts as a completed frame.
          if (bus.tx_done) begin
            cnt   <= '0;
            state <= after_done;
          end else if (bus.tx_busy) begin
            cnt   <= '0;
            state <= ST_WAIT_DONE;
          end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
            bus.timeout <= 1'b1;
            cnt         <= '0;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (bus.tx_done) begin
            cnt   <= '0;
            state <= after_done;
          end
        end
        ST_GAP: begin
          if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: dut0 runs with no inter-frame gap, dut1 with a 4-cycle gap.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   nvec = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) b0 ();
  uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) b1 ();

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .BUSY_TIMEOUT(15), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(b0));
  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .BUSY_TIMEOUT(15), .GAP_CYCLES(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(b1));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    b0.req = '0; b0.req_data = '0; b0.tx_busy = 1'b0; b0.tx_done = 1'b0;
    b1.req = '0; b1.req_data = '0; b1.tx_busy = 1'b0; b1.tx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_start(input int sel, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if ((sel == 0 && b0.tx_start === 1'b1) || (sel == 1 && b1.tx_start === 1'b1)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    nvec++; if (b0.grant !== 4'b0000) begin nfail++; $display("FAIL rst_grant got %b exp %b", b0.grant, 4'b0000); end
    nvec++; if (b0.tx_start !== 1'b0) begin nfail++; $display("FAIL rst_tx_start got %b exp 0", b0.tx_start); end
    nvec++; if (b0.tx_data !== 8'h00) begin nfail++; $display("FAIL rst_tx_data got %h exp 00", b0.tx_data); end
    nvec++; if (b0.active_id !== 2'd0) begin nfail++; $display("FAIL rst_active_id got %0d exp 0", b0.active_id); end
    nvec++; if (b0.timeout !== 1'b0) begin nfail++; $display("FAIL rst_timeout got %b exp 0", b0.timeout); end
    nvec++; if (b0.idle !== 1'b1 || b1.idle !== 1'b1) begin nfail++; $display("FAIL rst_idle got %b/%b exp 1/1", b0.idle, b1.idle); end
  endtask

  task automatic test_single();
    apply_reset();
    b0.req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    b0.req = 4'b0100;
    tick();
    nvec++; if (b0.grant !== 4'b0100) begin nfail++; $display("FAIL single_grant got %b exp %b", b0.grant, 4'b0100); end
    nvec++; if (b0.tx_start !== 1'b1) begin nfail++; $display("FAIL single_tx_start got %b exp 1", b0.tx_start); end
    nvec++; if (b0.tx_data !== 8'hA5) begin nfail++; $display("FAIL single_tx_data got %h exp a5", b0.tx_data); end
    nvec++; if (b0.active_id !== 2'd2) begin nfail++; $display("FAIL single_active_id got %0d exp 2", b0.active_id); end
    b0.req = '0;
    b0.tx_busy = 1'b1;
    tick();
    nvec++; if (b0.grant !== 4'b0000 || b0.tx_start !== 1'b0) begin nfail++; $display("FAIL single_pulse_width got grant=%b start=%b exp 0000/0", b0.grant, b0.tx_start); end
    repeat (9) tick();
    nvec++; if (b0.idle !== 1'b0) begin nfail++; $display("FAIL single_busy_idle got %b exp 0", b0.idle); end
    b0.tx_busy = 1'b0;
    b0.tx_done = 1'b1;
    tick();
    b0.tx_done = 1'b0;
    nvec++; if (b0.idle !== 1'b1) begin nfail++; $display("FAIL single_done_idle got %b exp 1", b0.idle); end
    nvec++; if (b0.tx_data !== 8'hA5 || b0.timeout !== 1'b0) begin nfail++; $display("FAIL single_hold got data=%h to=%b exp a5/0", b0.tx_data, b0.timeout); end
  endtask

  task automatic test_fairness();
    bit ok;
    int extra;
    logic [3:0] exp_g;
    apply_reset();
    extra = 0;
    b0.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    b0.req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_start(0, 10, ok);
      nvec++; if (!ok) begin nfail++; $display("FAIL fair_wait frame %0d got no tx_start exp tx_start", f); end
      exp_g = 4'b0001 << (f % 4);
      nvec++; if (b0.grant !== exp_g || b0.active_id !== 2'(f % 4)) begin nfail++; $display("FAIL fair_order frame %0d got grant=%b id=%0d exp %b/%0d", f, b0.grant, b0.active_id, exp_g, f % 4); end
      nvec++; if (b0.tx_data !== 8'h10 + 8'(f % 4)) begin nfail++; $display("FAIL fair_data frame %0d got %h exp %h", f, b0.tx_data, 8'h10 + 8'(f % 4)); end
      b0.tx_busy = 1'b1;
      for (int c = 0; c < 19; c++) begin
        tick();
        if (b0.tx_start !== 1'b0) extra++;
      end
      b0.tx_busy = 1'b0;
      b0.tx_done = 1'b1;
      tick();
      b0.tx_done = 1'b0;
    end
    b0.req = '0;
    nvec++; if (extra != 0) begin nfail++; $display("FAIL fair_one_grant got %0d extra starts exp 0", extra); end
  endtask

  task automatic test_timeout();
    int early;
    apply_reset();
    early = 0;
    b0.req_data = {8'h00, 8'h00, 8'h00, 8'h3C};
    b0.req = 4'b0001;
    tick();
    nvec++; if (b0.tx_start !== 1'b1) begin nfail++; $display("FAIL to_start got %b exp 1", b0.tx_start); end
    b0.req = '0;
    for (int c = 1; c < 15; c++) begin
      tick();
      if (b0.timeout !== 1'b0) early++;
    end
    nvec++; if (early != 0) begin nfail++; $display("FAIL to_early got %0d early pulses exp 0", early); end
    tick();
    nvec++; if (b0.timeout !== 1'b1) begin nfail++; $display("FAIL to_pulse got %b exp 1", b0.timeout); end
    nvec++; if (b0.idle !== 1'b1) begin nfail++; $display("FAIL to_idle got %b exp 1", b0.idle); end
    tick();
    nvec++; if (b0.timeout !== 1'b0) begin nfail++; $display("FAIL to_width got %b exp 0", b0.timeout); end
    b0.req_data = {8'h00, 8'h00, 8'h4D, 8'h00};
    b0.req = 4'b0010;
    tick();
    nvec++; if (b0.grant !== 4'b0010 || b0.tx_data !== 8'h4D) begin nfail++; $display("FAIL to_next got grant=%b data=%h exp 0010/4d", b0.grant, b0.tx_data); end
    b0.req = '0;
    b0.tx_busy = 1'b1;
    tick();
    b0.tx_busy = 1'b0;
    b0.tx_done = 1'b1;
    tick();
    b0.tx_done = 1'b0;
  endtask

  task automatic test_gap();
    int early;
    apply_reset();
    early = 0;
    b1.req_data = {8'h00, 8'h00, 8'h66, 8'h00};
    b1.req = 4'b0010;
    tick();
    nvec++; if (b1.grant !== 4'b0010) begin nfail++; $display("FAIL gap_first got %b exp 0010", b1.grant); end
    b1.tx_busy = 1'b1;
    repeat (3) tick();
    b1.tx_busy = 1'b0;
    b1.tx_done = 1'b1;
    tick();
    b1.tx_done = 1'b0;
    nvec++; if (b1.idle !== 1'b0) begin nfail++; $display("FAIL gap_in_gap got idle=%b exp 0", b1.idle); end
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (b1.tx_start !== 1'b0) early++;
    end
    nvec++; if (early != 0) begin nfail++; $display("FAIL gap_early got %0d starts exp 0", early); end
    nvec++; if (b1.idle !== 1'b1) begin nfail++; $display("FAIL gap_idle_m4 got %b exp 1", b1.idle); end
    tick();
    nvec++; if (b1.tx_start !== 1'b1 || b1.grant !== 4'b0010) begin nfail++; $display("FAIL gap_m5 got start=%b grant=%b exp 1/0010", b1.tx_start, b1.grant); end
    b1.req = '0;

    b0.req_data = {8'h00, 8'h00, 8'h67, 8'h00};
    b0.req = 4'b0010;
    tick();
    nvec++; if (b0.grant !== 4'b0010) begin nfail++; $display("FAIL nogap_first got %b exp 0010", b0.grant); end
    b0.tx_busy = 1'b1;
    repeat (3) tick();
    b0.tx_busy = 1'b0;
    b0.tx_done = 1'b1;
    tick();
    b0.tx_done = 1'b0;
    nvec++; if (b0.idle !== 1'b1 || b0.tx_start !== 1'b0) begin nfail++; $display("FAIL nogap_m got idle=%b start=%b exp 1/0", b0.idle, b0.tx_start); end
    tick();
    nvec++; if (b0.tx_start !== 1'b1 || b0.grant !== 4'b0010) begin nfail++; $display("FAIL nogap_m1 got start=%b grant=%b exp 1/0010", b0.tx_start, b0.grant); end
    b0.req = '0;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    b0.req_data = {8'h00, 8'h77, 8'h00, 8'h00};
    b0.req = 4'b0100;
    tick();
    b0.req = '0;
    b0.tx_busy = 1'b1;
    repeat (2) tick();
    nvec++; if (b0.idle !== 1'b0) begin nfail++; $display("FAIL mrst_pre got idle=%b exp 0", b0.idle); end
    reset_n = 1'b0;
    #1;
    nvec++; if (b0.idle !== 1'b1 || b0.tx_data !== 8'h00 || b0.active_id !== 2'd0 || b0.grant !== 4'b0000) begin
      nfail++; $display("FAIL mrst_async got idle=%b data=%h id=%0d grant=%b exp 1/00/0/0000", b0.idle, b0.tx_data, b0.active_id, b0.grant);
    end
    b0.tx_busy = 1'b0;
    tick();
    reset_n = 1'b1;
    b0.req_data = {8'h33, 8'h00, 8'h00, 8'h11};
    b0.req = 4'b1001;
    tick();
    nvec++; if (b0.grant !== 4'b0001 || b0.tx_data !== 8'h11) begin nfail++; $display("FAIL mrst_ptr got grant=%b data=%h exp 0001/11", b0.grant, b0.tx_data); end
    b0.req = '0;
    b0.tx_done = 1'b1;
    tick();
    b0.tx_done = 1'b0;
    b0.req = 4'b1000;
    tick();
    nvec++; if (b0.grant !== 4'b1000 || b0.active_id !== 2'd3 || b0.tx_data !== 8'h33) begin
      nfail++; $display("FAIL mrst_req3 got grant=%b id=%0d data=%h exp 1000/3/33", b0.grant, b0.active_id, b0.tx_data);
    end
    b0.req = '0;
    b0.tx_done = 1'b1;
    tick();
    b0.tx_done = 1'b0;
  endtask

  task automatic test_done_in_wait_busy();
    int pulses;
    apply_reset();
    pulses = 0;
    b0.req_data = {8'h00, 8'h00, 8'h00, 8'h5A};
    b0.req = 4'b0001;
    tick();
    nvec++; if (b0.tx_start !== 1'b1 || b0.tx_data !== 8'h5A) begin nfail++; $display("FAIL dwb_start got start=%b data=%h exp 1/5a", b0.tx_start, b0.tx_data); end
    b0.req = '0;
    b0.tx_done = 1'b1;
    tick();
    b0.tx_done = 1'b0;
    nvec++; if (b0.idle !== 1'b1) begin nfail++; $display("FAIL dwb_idle got %b exp 1", b0.idle); end
    for (int c = 0; c < 20; c++) begin
      if (b0.timeout !== 1'b0) pulses++;
      tick();
    end
    nvec++; if (pulses != 0) begin nfail++; $display("FAIL dwb_no_timeout got %0d pulses exp 0", pulses); end
  endtask

  initial begin
    b0.req = '0; b0.req_data = '0; b0.tx_busy = 1'b0; b0.tx_done = 1'b0;
    b1.req = '0; b1.req_data = '0; b1.tx_busy = 1'b0; b1.tx_done = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_gap();
    test_mid_reset();
    test_done_in_wait_busy();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
